// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs one req/ack data-bus transaction per
// EX/MEM access, stalls the pipe while it is outstanding, formats loads.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   req_valid, mem_read, mem_write, size, unsigned_ld, addr, wdata
//                       EX/MEM access request
//   bus_req, bus_we, bus_addr, bus_be, bus_wdata (registered), bus_rdata, bus_ack
//                       data-memory bus
//   stall               freeze the upstream pipeline registers
//   read_data           formatted load data for MEM/WB (registered)
//   done, misaligned, bus_err
//                       completion / reject / timeout pulses
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall,
  output logic [31:0] read_data,
  output logic        done,
  output logic        misaligned,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic             access;
  logic             aligned;
  logic             launch;
  logic             tmo;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic [1:0]       sz_q;
  logic [1:0]       off_q;
  logic             uns_q;
  logic [3:0]       be;
  logic [31:0]      wd;
  logic [31:0]      lane;
  logic [31:0]      fmt;

  assign access = req_valid & (mem_read | mem_write);
  assign launch = (state == IDLE) & access & aligned;
  assign tmo    = (cnt == CNT_W'(TIMEOUT - 1));

  // Alignment, byte enables and lane-replicated store data.
  always_comb begin
    aligned = 1'b0;
    be      = 4'b1111;
    wd      = wdata;
    unique case (1'b1)
      size == 2'b00: begin
        aligned = 1'b1;
        be      = 4'b0001 << addr[1:0];
        wd      = {4{wdata[7:0]}};
      end
      size == 2'b01: begin
        aligned = ~addr[0];
        be      = 4'b0011 << {addr[1], 1'b0};
        wd      = {2{wdata[15:0]}};
      end
      default: begin
        aligned = (addr[1:0] == 2'b00);
        be      = 4'b1111;
        wd      = wdata;
      end
    endcase
  end

  // Load formatting uses the size/offset latched at launch; a word is
  // always aligned, so its lane is the raw bus word.
  assign lane = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    fmt = lane;
    unique case (1'b1)
      sz_q == 2'b00:
        fmt = uns_q ? {24'd0, lane[7:0]}
                    : {{24{lane[7]}}, lane[7:0]};
      sz_q == 2'b01:
        fmt = uns_q ? {16'd0, lane[15:0]}
                    : {{16{lane[15]}}, lane[15:0]};
      default:
        fmt = lane;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    stall      = 1'b0;
    done       = 1'b0;
    bus_err    = 1'b0;
    misaligned = 1'b0;
    unique case (state)
      IDLE: begin
        stall      = launch;
        misaligned = access & ~aligned;
        if (launch) state_nx = ACCESS;
      end
      ACCESS: begin
        stall = 1'b1;
        // An ack on the timeout cycle still completes normally.
        if (bus_ack || tmo) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        bus_err  = err;
        // req_valid still shows the finished instruction here.
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      read_data <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      sz_q      <= '0;
      off_q     <= '0;
      uns_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (launch) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be;
            bus_wdata <= wd;
            sz_q      <= size;
            uns_q     <= unsigned_ld;
            off_q     <= addr[1:0];
            cnt       <= '0;
          end else if (misaligned) begin
            read_data <= '0;
          end
        end
        ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) read_data <= fmt;
          end else if (tmo) begin
            bus_req   <= 1'b0;
            read_data <= '0;
            err       <= 1'b1;
          end
        end
        DONE: err <= 1'b0;
        default: err <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit of the 5-stage MIPS pipeline; drives the data-memory bus on the producer side of the MEM/WB pipeline register.
- Takes the EX/MEM access request and runs a req/ack bus transaction.
- Holds the pipeline stalled while the transaction is outstanding.
- Delivers size-formatted, sign/zero-extended load data (read_data) for MEM/WB to capture.

Parameters:
- TIMEOUT, 16, ACCESS cycles without bus_ack before the transaction is aborted with bus_err.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  EX/MEM holds a valid instruction.
- mem_read  in  1  load request.
- mem_write  in  1  store request; has priority over mem_read when both are high.
- size  in  2  00 byte, 01 halfword, 10/11 word.
- unsigned_ld  in  1  1 = zero-extend loads, 0 = sign-extend.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  1 = write, registered.
- bus_addr  out  32  {addr[31:2],2'b00}, registered.
- bus_be  out  4  byte enables, registered.
- bus_wdata  out  32  lane-replicated store data, registered.
- bus_rdata  in  32  read data, valid when bus_ack = 1.
- bus_ack  in  1  slave completion, sampled only in ACCESS.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- read_data  out  32  formatted load data, registered.
- done  out  1  one-cycle pulse: access complete, pipeline advances this edge.
- misaligned  out  1  combinational pulse: request rejected for misalignment.
- bus_err  out  1  one-cycle pulse in DONE after a timeout.

Behaviour:
- Access condition: access = req_valid & (mem_read | mem_write).
- Alignment:
  - aligned = byte, or half with addr[0] = 0, or word with addr[1:0] = 0.
  - misaligned = IDLE & access & ~aligned. No bus cycle, stall = 0, read_data <= 0 at the next edge.
- States: IDLE, ACCESS, DONE. 2-bit state register.
- IDLE:
  - On access & aligned: register bus_req = 1, bus_we = mem_write, bus_addr, bus_be, bus_wdata, and latch size, unsigned_ld and addr[1:0].
  - Counter <= 0; next state ACCESS.
- ACCESS:
  - Bus outputs held stable; counter increments each cycle.
  - bus_ack = 1: bus_req <= 0; for a load, read_data <= format(bus_rdata); next state DONE.
  - Counter reaches TIMEOUT-1 without ack: bus_req <= 0, read_data <= 0, err flag set; next state DONE.
  - An ack arriving on the timeout cycle wins (normal completion).
- DONE:
  - done = 1, bus_err = err flag, stall = 0; next state IDLE unconditionally.
  - req_valid in DONE still describes the completed instruction, so it is never relaunched.
  - The err flag clears on leaving DONE.
- stall = (state == ACCESS) | (state == IDLE & access & aligned).
- Latency: a zero-wait slave (ack in first ACCESS cycle) gives 2 stall cycles, then DONE. Each additional wait cycle adds 1 stall cycle.
- Byte enables, with o = addr[1:0]:
  - byte: 4'b0001 << o.
  - half: 4'b0011 << {addr[1],1'b0}.
  - word: 4'b1111.
- Store data replication:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load formatting:
  - Lane = bus_rdata >> (8*o).
  - byte: bits [7:0] extended; half: bits [15:0] extended; word: unchanged.
  - Extension: zero if unsigned_ld, else sign.
- Stores leave read_data unchanged.
- Non-access instructions (req_valid = 0 or no read/write): stay in IDLE, no bus activity, read_data unchanged.
- Reset, asynchronous:
  - state = IDLE.
  - bus_req, bus_we = 0; bus_addr, bus_be, bus_wdata = 0.
  - read_data = 0; counter = 0; err flag = 0.
  - done, bus_err = 0; stall = 0 while access = 0.
  - Reset mid-ACCESS drops bus_req immediately; a later bus_ack is ignored in IDLE.

Test Plan:
1. Word load, addr = 0x0000_0010, slave acks in first ACCESS cycle with 0xDEADBEEF -> bus_be = 4'b1111, stall high 2 cycles, done pulse, read_data = 0xDEADBEEF.
2. Signed byte load, addr = 0x13, bus_rdata = 0x80112233 -> bus_be = 4'b1000, read_data = 0xFFFFFF80. Repeat with unsigned_ld = 1 -> 0x00000080.
3. Halfword store, addr = 0x22, wdata = 0x0000ABCD, ack after 3 wait cycles -> bus_we = 1, bus_be = 4'b1100, bus_wdata = 0xABCDABCD, stall high 5 cycles, read_data unchanged.
4. Word load at addr = 0x06 -> misaligned = 1, bus_req never asserted, stall = 0, read_data = 0 next cycle.
5. Slave never acks, TIMEOUT = 16 -> bus_req drops after 16 ACCESS cycles, DONE with bus_err = 1 and done = 1, read_data = 0. Then an immediate new load completes normally.
6. rst asserted two cycles into ACCESS, then bus_ack pulsed after release -> all outputs 0 immediately, state IDLE, late ack produces no done and no read_data change.
